// File: rtl/wb_led_pwm_pkg.sv
// wb_led_pwm_pkg: shared constants for the Wishbone LED PWM peripheral.
//   - word offsets of the four registers (byte address bits [3:2])
//   - CTRL and BLINK field positions
//   - PHASE_MAX: last phase value of a PWM frame (frame is 255 ticks long)
package wb_led_pwm_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_DUTY_LO = 2'd1;
  localparam logic [1:0] REG_DUTY_HI = 2'd2;
  localparam logic [1:0] REG_BLINK   = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PRESCALE_LSB = 8;
  localparam int BLINK_MASK_LSB    = 0;
  localparam int BLINK_PERIOD_LSB  = 16;

  localparam logic [7:0] PHASE_MAX = 8'd254;

endpackage

// File: rtl/led_pwm_core.sv
// led_pwm_core: prescaler, PWM phase, blink frame counter and per-LED
// comparators.
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset
//   en_i             global enable; when low all counters are held idle
//   prescale_i       P: one phase step every P+1 clocks
//   duty_i[8]        per-LED duty, LED on while phase < duty
//   mask_i           LEDs whose output is gated by the blink state
//   period_i         B: blink half-period in frames, 0 = no blinking
//   lit_o            combinational lit pattern (registered by the top)
module led_pwm_core
  import wb_led_pwm_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            en_i,
  input  logic [7:0]      prescale_i,
  input  logic [7:0][7:0] duty_i,
  input  logic [7:0]      mask_i,
  input  logic [15:0]     period_i,
  output logic [7:0]      lit_o
);

  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  phase_q, phase_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        bstate_q, bstate_d;
  logic        tick;
  logic        frame;

  // Exact-match tick: lowering P below pcnt lets pcnt run through 255
  // and wrap before the next tick instead of forcing a restart.
  assign tick  = en_i && (pcnt_q == prescale_i);
  assign frame = tick && (phase_q == PHASE_MAX);

  always_comb begin
    pcnt_d   = pcnt_q + 8'd1;
    phase_d  = phase_q;
    fcnt_d   = fcnt_q;
    bstate_d = bstate_q;
    if (!en_i) begin
      pcnt_d   = 8'd0;
      phase_d  = 8'd0;
      fcnt_d   = 16'd0;
      bstate_d = 1'b1;
    end else begin
      if (tick) begin
        pcnt_d  = 8'd0;
        phase_d = frame ? 8'd0 : phase_q + 8'd1;
      end
      if (period_i == 16'd0) begin
        fcnt_d   = 16'd0;
        bstate_d = 1'b1;
      end else if (frame) begin
        if (fcnt_q == period_i - 16'd1) begin
          fcnt_d   = 16'd0;
          bstate_d = ~bstate_q;
        end else if (fcnt_q >= period_i) begin
          // Period shrunk below the running count: restart the count.
          fcnt_d = 16'd0;
        end else begin
          fcnt_d = fcnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pcnt_q   <= 8'd0;
      phase_q  <= 8'd0;
      fcnt_q   <= 16'd0;
      bstate_q <= 1'b1;
    end else begin
      pcnt_q   <= pcnt_d;
      phase_q  <= phase_d;
      fcnt_q   <= fcnt_d;
      bstate_q <= bstate_d;
    end
  end

  // Phase tops out at 254, so duty 255 is always on and duty 0 never.
  always_comb begin
    lit_o = '0;
    for (int i = 0; i < 8; i++) begin
      lit_o[i] = en_i && (phase_q < duty_i[i]) && (bstate_q || !mask_i[i]);
    end
  end

endmodule

// File: rtl/wb_led_pwm.sv
// wb_led_pwm: Wishbone classic slave driving eight PWM/blink LEDs.
// Ports:
//   wb_clk_i, wb_rst_n_i   clock, synchronous active-low reset
//   wb_adr_i[3:0]          byte address, [3:2] selects the word
//   wb_dat_i, wb_sel_i     write data and byte enables
//   wb_we_i, wb_cyc_i, wb_stb_i   Wishbone classic controls
//   wb_dat_o, wb_ack_o     registered read data and acknowledge
//   led_o[7:0]             registered LED drive (inverted if LED_ACTIVE_LOW)
// Registers: 0x0 CTRL {P[15:8], en[0]}, 0x4 DUTY_LO, 0x8 DUTY_HI,
//            0xC BLINK {B[31:16], M[7:0]}.
module wb_led_pwm
  import wb_led_pwm_pkg::*;
#(
  parameter bit         LED_ACTIVE_LOW = 1'b0,
  parameter logic [7:0] RESET_DUTY     = 8'h00
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [7:0]  led_o
);

  logic            en_q, en_d;
  logic [7:0]      prescale_q, prescale_d;
  logic [7:0][7:0] duty_q, duty_d;
  logic [7:0]      mask_q, mask_d;
  logic [15:0]     period_q, period_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [7:0]      led_q, led_d;
  logic [7:0]      lit;
  logic [31:0]     rdata;
  logic [1:0]      word;
  logic            req;
  logic            unused_adr_bits;

  // Handshake: a request is cyc & stb while ack is low. It is accepted
  // on the next rising edge, which raises ack for exactly one cycle and
  // commits write data; with stb held, ack therefore pulses every other
  // cycle. dat_o carries read data only while ack is high, else 0.
  assign req             = wb_cyc_i && wb_stb_i && !ack_q;
  assign word            = wb_adr_i[3:2];
  assign unused_adr_bits = ^wb_adr_i[1:0];

  always_comb begin
    rdata = '0;
    case (word)
      REG_CTRL:    rdata = {16'h0, prescale_q, 7'h0, en_q};
      REG_DUTY_LO: rdata = {duty_q[3], duty_q[2], duty_q[1], duty_q[0]};
      REG_DUTY_HI: rdata = {duty_q[7], duty_q[6], duty_q[5], duty_q[4]};
      REG_BLINK:   rdata = {period_q, 8'h0, mask_q};
    endcase
  end

  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    mask_d     = mask_q;
    period_d   = period_q;
    ack_d      = req;
    dat_d      = (req && !wb_we_i) ? rdata : 32'h0;
    led_d      = lit ^ {8{LED_ACTIVE_LOW}};
    if (req && wb_we_i) begin
      case (word)
        REG_CTRL: begin
          if (wb_sel_i[0]) en_d       = wb_dat_i[CTRL_EN_BIT];
          if (wb_sel_i[1]) prescale_d = wb_dat_i[CTRL_PRESCALE_LSB +: 8];
        end
        REG_DUTY_LO: begin
          for (int b = 0; b < 4; b++)
            if (wb_sel_i[b]) duty_d[b] = wb_dat_i[8*b +: 8];
        end
        REG_DUTY_HI: begin
          for (int b = 0; b < 4; b++)
            if (wb_sel_i[b]) duty_d[b+4] = wb_dat_i[8*b +: 8];
        end
        REG_BLINK: begin
          if (wb_sel_i[0]) mask_d         = wb_dat_i[BLINK_MASK_LSB +: 8];
          if (wb_sel_i[2]) period_d[7:0]  = wb_dat_i[BLINK_PERIOD_LSB +: 8];
          if (wb_sel_i[3]) period_d[15:8] = wb_dat_i[BLINK_PERIOD_LSB+8 +: 8];
        end
      endcase
    end
  end

  // Reset wins over a pending request: no ack and the write is dropped.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      en_q       <= 1'b0;
      prescale_q <= 8'h00;
      duty_q     <= {8{RESET_DUTY}};
      mask_q     <= 8'h00;
      period_q   <= 16'h0000;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      led_q      <= {8{LED_ACTIVE_LOW}};
    end else begin
      en_q       <= en_d;
      prescale_q <= prescale_d;
      duty_q     <= duty_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      led_q      <= led_d;
    end
  end

  led_pwm_core u_core (
    .clk_i      (wb_clk_i),
    .rst_n_i    (wb_rst_n_i),
    .en_i       (en_q),
    .prescale_i (prescale_q),
    .duty_i     (duty_q),
    .mask_i     (mask_q),
    .period_i   (period_q),
    .lit_o      (lit)
  );

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign led_o    = led_q;

endmodule

// File: tb/tb_wb_led_pwm.sv
module tb_wb_led_pwm;

  localparam bit         ACT_LOW = 1'b0;
  localparam logic [7:0] RST_DUTY = 8'h00;

  logic        wb_clk_i;
  logic        wb_rst_n_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  led_o;

  int checks;
  int failures;

  // Shadow of the register file as software sees it.
  logic [31:0] sh[4];
  logic [31:0] impl_mask[4];

  typedef struct {
    logic [3:0]  adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[18];

  wb_led_pwm #(.LED_ACTIVE_LOW(ACT_LOW), .RESET_DUTY(RST_DUTY)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_i   (wb_sel_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .led_o      (led_o)
  );

  // Clock / watchdog
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic reset_shadow();
    sh[0] = 32'h0;
    sh[1] = {4{RST_DUTY}};
    sh[2] = {4{RST_DUTY}};
    sh[3] = 32'h0;
  endtask

  task automatic sh_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    int w;
    w = int'(adr[3:2]);
    for (int b = 0; b < 4; b++)
      if (sel[b]) sh[w][8*b +: 8] = dat[8*b +: 8] & impl_mask[w][8*b +: 8];
  endtask

  // Reference: LED pattern t clocks after the enabling write, with the
  // shadow configuration held constant since then.
  function automatic logic [7:0] model_led(input int t);
    int p1, ph, fr, b;
    logic bst;
    logic [7:0] d;
    logic [7:0] r;
    p1 = int'(sh[0][15:8]) + 1;
    ph = (t / p1) % 255;
    fr = t / (255 * p1);
    b  = int'(sh[3][31:16]);
    bst = (b == 0) ? 1'b1 : (((fr / b) % 2) == 0);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      d = (i < 4) ? sh[1][8*i +: 8] : sh[2][8*(i-4) +: 8];
      r[i] = sh[0][0] && (ph < int'(d)) && (bst || !sh[3][i]);
    end
    return r ^ {8{ACT_LOW}};
  endfunction

  // Driver: one Wishbone classic access, caller is at a falling edge.
  task automatic bus(input logic [3:0] adr, input logic we, input logic [3:0] sel,
                     input logic [31:0] wdat, output logic [31:0] rdat, output bit got);
    got  = 1'b0;
    rdat = '0;
    wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = wdat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge wb_clk_i);
      if (wb_ack_o) begin
        got  = 1'b1;
        rdat = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    bit got;
    bus(adr, 1'b1, sel, dat, r, got);
    check("write_ack", {31'h0, got}, 32'h1);
    if (got) sh_write(adr, dat, sel);
  endtask

  task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
    logic [31:0] r;
    bit got;
    bus(adr, 1'b0, 4'hF, 32'h0, r, got);
    check({name, "_ack"}, {31'h0, got}, 32'h1);
    check(name, r, exp);
    @(negedge wb_clk_i);
    check({name, "_ack_width"}, {31'h0, wb_ack_o}, 32'h0);
    check({name, "_dat_idle"}, wb_dat_o, 32'h0);
  endtask

  // Scoreboard over n cycles of LED output, right after an enabling write.
  task automatic run_trace(input string name, input int n, output int hi0, output int hi1, output int tr0);
    int bad;
    logic [7:0] exp_q[$];
    logic prev0;
    bad = 0; hi0 = 0; hi1 = 0; tr0 = 0; prev0 = 1'b0;
    for (int k = 0; k < n; k++) exp_q.push_back(model_led(k));
    for (int k = 1; k <= n; k++) begin
      @(negedge wb_clk_i);
      if (led_o !== exp_q.pop_front()) bad++;
      hi0 += int'(led_o[0]);
      hi1 += int'(led_o[1]);
      if (k > 1 && led_o[0] != prev0) tr0++;
      prev0 = led_o[0];
    end
    check(name, bad, 0);
  endtask

  initial begin
    int hi0, hi1, tr0, acks, pairs, n, p, b;
    logic prev_ack;
    logic [3:0] sel;
    logic [3:0] radr;
    checks = 0; failures = 0;
    impl_mask[0] = 32'h0000FF01;
    impl_mask[1] = 32'hFFFFFFFF;
    impl_mask[2] = 32'hFFFFFFFF;
    impl_mask[3] = 32'hFFFF00FF;
    reset_shadow();

    vecs[0]  = '{4'h0, 1'b0, 4'hF, 32'h0, 32'h00000000};
    vecs[1]  = '{4'h4, 1'b0, 4'hF, 32'h0, 32'h00000000};
    vecs[2]  = '{4'h8, 1'b0, 4'hF, 32'h0, 32'h00000000};
    vecs[3]  = '{4'hC, 1'b0, 4'hF, 32'h0, 32'h00000000};
    vecs[4]  = '{4'h8, 1'b1, 4'b0010, 32'h0000AB00, 32'h0};
    vecs[5]  = '{4'h8, 1'b0, 4'hF, 32'h0, 32'h0000AB00};
    vecs[6]  = '{4'h8, 1'b1, 4'b1001, 32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{4'h8, 1'b0, 4'hF, 32'h0, 32'hFF00ABFF};
    vecs[8]  = '{4'h0, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{4'h0, 1'b0, 4'hF, 32'h0, 32'h0000FF01};
    vecs[10] = '{4'hC, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0};
    vecs[11] = '{4'hF, 1'b0, 4'hF, 32'h0, 32'hFFFF00FF};
    vecs[12] = '{4'h5, 1'b1, 4'b0100, 32'h00C30000, 32'h0};
    vecs[13] = '{4'h6, 1'b0, 4'hF, 32'h0, 32'h00C30000};
    vecs[14] = '{4'h0, 1'b1, 4'hF, 32'h0, 32'h0};
    vecs[15] = '{4'hC, 1'b1, 4'hF, 32'h0, 32'h0};
    vecs[16] = '{4'h8, 1'b1, 4'hF, 32'h0, 32'h0};
    vecs[17] = '{4'h4, 1'b1, 4'hF, 32'h0, 32'h0};

    // Reset
    wb_rst_n_i = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("reset_led", led_o, {8{ACT_LOW}});
    check("reset_ack", wb_ack_o, 0);
    check("reset_dat", wb_dat_o, 0);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);

    // Register table
    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].adr, vecs[i].dat, vecs[i].sel);
      else rd(vecs[i].adr, vecs[i].exp, $sformatf("vec%0d_read", i));
    end
    check("led_after_table", led_o, {8{ACT_LOW}});

    // Duty 255, P = 0: LED0 constantly on, others off
    wr(4'h4, 32'h000000FF, 4'hF);
    wr(4'h0, 32'h00000001, 4'hF);
    run_trace("const_on_trace", 600, hi0, hi1, tr0);
    check("const_on_hi0", hi0, 600);
    check("const_on_hi1", hi1, 0);

    // Duty 64, P = 3: 256 lit clocks per 1020-clock frame
    wr(4'h0, 32'h0, 4'hF);
    wr(4'h4, 32'h00000040, 4'hF);
    wr(4'h0, 32'h00000301, 4'hF);
    run_trace("duty64_trace", 1020, hi0, hi1, tr0);
    check("duty64_hi0", hi0, 256);
    check("duty64_edges", tr0, 1);

    // Blink: B = 2, M = LED0, duty0 = duty1 = 255, P = 0
    wr(4'h0, 32'h0, 4'hF);
    wr(4'h4, 32'h0000FFFF, 4'hF);
    wr(4'hC, 32'h00020001, 4'hF);
    wr(4'h0, 32'h00000001, 4'hF);
    run_trace("blink_trace", 2040, hi0, hi1, tr0);
    check("blink_hi0", hi0, 1020);
    check("blink_toggles", tr0, 3);
    check("blink_hi1", hi1, 2040);

    // stb/cyc held for 6 cycles: three single-cycle acks
    wb_adr_i = 4'h0; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    acks = 0; pairs = 0; prev_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      if (wb_ack_o) acks++;
      if (wb_ack_o && prev_ack) pairs++;
      prev_ack = wb_ack_o;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    check("b2b_acks", acks, 3);
    check("b2b_wide_acks", pairs, 0);
    @(negedge wb_clk_i);

    // Reset during a pending write
    wr(4'h4, 32'h0000005A, 4'hF);
    wb_rst_n_i = 1'b0;
    wb_adr_i = 4'h4; wb_dat_i = 32'h12345678; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    acks = 0;
    repeat (2) begin
      @(negedge wb_clk_i);
      if (wb_ack_o) acks++;
    end
    check("rst_mid_write_ack", acks, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_rst_n_i = 1'b1;
    reset_shadow();
    @(negedge wb_clk_i);
    rd(4'h4, {4{RST_DUTY}}, "rst_write_discarded");
    check("rst_led", led_o, {8{ACT_LOW}});

    // Randomized configurations against the reference model
    for (int trial = 0; trial < 6; trial++) begin
      p = $urandom_range(0, 2);
      b = $urandom_range(0, 2);
      wr(4'h0, {16'h0, 8'(p), 8'h00}, 4'hF);
      wr(4'h4, $urandom, 4'hF);
      sel = 4'($urandom_range(1, 15));
      wr(4'h8, $urandom, sel);
      wr(4'hC, {16'(b), 8'($urandom), 8'($urandom)}, 4'hF);
      radr = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rd(radr, sh[radr[3:2]], $sformatf("rand%0d_read", trial));
      wr(4'h0, 32'h00000001, 4'b0001);
      n = 255 * (p + 1) * 2 * ((b == 0) ? 1 : b);
      if (n > 2600) n = 2600;
      run_trace($sformatf("rand%0d_trace", trial), n, hi0, hi1, tr0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
